// File: rtl/seq_detector_1011.sv
// ---------------------------------------------------------------------------
// seq_detector_1011
//
// Moore FSM that flags every occurrence of the serial pattern 1011 on D.
// D is the registered output of the upstream DFF stage and is consumed only
// on rising clk edges where EN=1. A wrapping counter tallies detections.
//
// Configuration macro:
//   SEQ_DET_OVERLAP_EN  defined   -> overlapping detection (S4 --0--> S2)
//                       undefined -> non-overlapping detection (S4 --0--> S0)
//
// Ports:
//   clk    in   1      rising-edge clock
//   CLR    in   1      asynchronous, active-high reset (priority over EN, D)
//   D      in   1      serial data bit
//   EN     in   1      sample enable; state and CNT hold when low
//   DET    out  1      high while in the detect state S4
//   DETp   out  1      always ~DET
//   CNT    out  CNT_W  detection count, wraps modulo 2^CNT_W
//   STATE  out  3      current state encoding (debug/verification)
// ---------------------------------------------------------------------------
module seq_detector_1011 #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             D,
  input  logic             EN,
  output logic             DET,
  output logic             DETp,
  output logic [CNT_W-1:0] CNT,
  output logic [2:0]       STATE
);

  typedef enum logic [2:0] {
    S0 = 3'd0,  // idle
    S1 = 3'd1,  // seen 1
    S2 = 3'd2,  // seen 10
    S3 = 3'd3,  // seen 101
    S4 = 3'd4   // seen 1011 -> detect
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;

  // State register. EN gates the update so a disabled edge holds everything.
  // NOTE: sequential state uses non-blocking (<=) so all flops see pre-edge values.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state <= S0;
    end else if (EN) begin
      state <= state_next;
    end
  end

  // Next-state logic. Encodings 5-7 fall into the default and recover to S0.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = S0;
    case (state)
      S0:      state_next = D ? S1 : S0;
      S1:      state_next = D ? S1 : S2;
      S2:      state_next = D ? S3 : S0;
      S3:      state_next = D ? S4 : S2;
`ifdef SEQ_DET_OVERLAP_EN
      // Trailing "1" of the match doubles as the leading "1" of the next one.
      S4:      state_next = D ? S1 : S2;
`else
      // Every match needs four fresh bits.
      S4:      state_next = D ? S1 : S0;
`endif
      default: state_next = S0;
    endcase
  end

  // Detection counter: bumps on the same edge that enters S4, so it moves
  // together with the rising DET. Wraps naturally with no saturation.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      cnt <= '0;
    end else if (EN && (state_next == S4)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Moore outputs, decoded from registered state only (no path from D).
  always_comb begin
    DET   = (state == S4);
    DETp  = ~DET;
    CNT   = cnt;
    STATE = state;
  end

endmodule

// File: tb/tb_seq_detector_1011.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_1011
//
// Directed testbench for seq_detector_1011 (CNT_W = 4). Inputs change on the
// falling edge; outputs are sampled 1 time unit after the rising edge.
// Expected values follow the build selected by SEQ_DET_OVERLAP_EN.
// ---------------------------------------------------------------------------
module tb_seq_detector_1011;

  localparam int CNT_W = 4;

  logic             clk;
  logic             CLR;
  logic             D;
  logic             EN;
  logic             DET;
  logic             DETp;
  logic [CNT_W-1:0] CNT;
  logic [2:0]       STATE;

  int compared   = 0;
  int mismatched = 0;

  seq_detector_1011 #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .CLR   (CLR),
    .D     (D),
    .EN    (EN),
    .DET   (DET),
    .DETp  (DETp),
    .CNT   (CNT),
    .STATE (STATE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one bit on the falling edge, then sample just after the rising edge.
  task automatic step(input logic d, input logic en);
    @(negedge clk);
    D  = d;
    EN = en;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    @(negedge clk);
    EN  = 1'b0;
    D   = 1'b0;
    CLR = 1'b1;
    #2;
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    CLR = 1'b1;
    #1;
    compared++;
    if (STATE !== 3'd0) begin
      mismatched++;
      $display("FAIL reset_state: got %0d want 0", STATE);
    end
    compared++;
    if (DET !== 1'b0 || DETp !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_det: got DET=%b DETp=%b want DET=0 DETp=1", DET, DETp);
    end
    compared++;
    if (CNT !== 4'd0) begin
      mismatched++;
      $display("FAIL reset_cnt: got %0d want 0", CNT);
    end
    // CLR wins over an enabled D=1 edge.
    EN = 1'b1;
    D  = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (STATE !== 3'd0 || CNT !== 4'd0) begin
      mismatched++;
      $display("FAIL reset_priority: got STATE=%0d CNT=%0d want 0 0", STATE, CNT);
    end
    @(negedge clk);
    EN  = 1'b0;
    D   = 1'b0;
    CLR = 1'b0;
  endtask

  // Stream 1,0,1,1,0,1,1 -- also the minimum-spacing back-to-back case.
  task automatic test_stream();
    logic       bits    [7];
    logic [2:0] exp_st  [7];
    logic [3:0] exp_cnt;
    bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`ifdef SEQ_DET_OVERLAP_EN
    exp_st  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd4};
    exp_cnt = 4'd2;
`else
    exp_st  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd1};
    exp_cnt = 4'd1;
`endif
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(bits[i], 1'b1);
      compared++;
      if (STATE !== exp_st[i] || DET !== (exp_st[i] == 3'd4) || DETp !== (exp_st[i] != 3'd4)) begin
        mismatched++;
        $display("FAIL stream_bit%0d: got STATE=%0d DET=%b DETp=%b want STATE=%0d DET=%b",
                 i + 1, STATE, DET, DETp, exp_st[i], (exp_st[i] == 3'd4));
      end
    end
    compared++;
    if (CNT !== exp_cnt) begin
      mismatched++;
      $display("FAIL stream_cnt: got %0d want %0d", CNT, exp_cnt);
    end
  endtask

  task automatic test_enable_hold();
    do_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(logic'(i[0] == 1'b0), 1'b0);  // D toggles 1,0,1,0,1 while disabled
      compared++;
      if (STATE !== 3'd3 || CNT !== 4'd0) begin
        mismatched++;
        $display("FAIL en_hold_cycle%0d: got STATE=%0d CNT=%0d want 3 0", i, STATE, CNT);
      end
    end
    step(1'b1, 1'b1);
    compared++;
    if (STATE !== 3'd4 || DET !== 1'b1 || CNT !== 4'd1) begin
      mismatched++;
      $display("FAIL en_resume: got STATE=%0d DET=%b CNT=%0d want 4 1 1", STATE, DET, CNT);
    end
    // DET persists while EN stays low.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    compared++;
    if (DET !== 1'b1 || CNT !== 4'd1) begin
      mismatched++;
      $display("FAIL en_det_hold: got DET=%b CNT=%0d want 1 1", DET, CNT);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);  // S4, CNT=1
    step(1'b1, 1'b1);  // S1
    step(1'b0, 1'b1);  // S2
    step(1'b1, 1'b1);  // S3
    compared++;
    if (STATE !== 3'd3 || CNT !== 4'd1) begin
      mismatched++;
      $display("FAIL mid_pre: got STATE=%0d CNT=%0d want 3 1", STATE, CNT);
    end
    @(negedge clk);
    CLR = 1'b1;
    #1;
    compared++;
    if (STATE !== 3'd0 || CNT !== 4'd0 || DET !== 1'b0 || DETp !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_async: got STATE=%0d CNT=%0d DET=%b DETp=%b want 0 0 0 1",
               STATE, CNT, DET, DETp);
    end
    #1;
    CLR = 1'b0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    compared++;
    if (STATE !== 3'd1 || DET !== 1'b0 || CNT !== 4'd0) begin
      mismatched++;
      $display("FAIL mid_restart: got STATE=%0d DET=%b CNT=%0d want 1 0 0", STATE, DET, CNT);
    end
  endtask

  task automatic test_counter_wrap();
    int         pulses;
    logic       det_prev;
    logic [3:0] exp_cnt;
    pulses   = 0;
    det_prev = 1'b0;
    exp_cnt  = 4'd0;
    do_reset();
`ifdef SEQ_DET_OVERLAP_EN
    step(1'b1, 1'b1);
`endif
    for (int r = 0; r < 16; r++) begin
`ifndef SEQ_DET_OVERLAP_EN
      step(1'b1, 1'b1);
      if (DET && !det_prev) pulses++;
      det_prev = DET;
`endif
      step(1'b0, 1'b1);
      if (DET && !det_prev) pulses++;
      det_prev = DET;
      step(1'b1, 1'b1);
      if (DET && !det_prev) pulses++;
      det_prev = DET;
      step(1'b1, 1'b1);
      if (DET && !det_prev) pulses++;
      det_prev = DET;
      exp_cnt = exp_cnt + 4'd1;
      compared++;
      if (DET !== 1'b1 || CNT !== exp_cnt) begin
        mismatched++;
        $display("FAIL wrap_rep%0d: got DET=%b CNT=%0d want 1 %0d", r, DET, CNT, exp_cnt);
      end
    end
    compared++;
    if (CNT !== 4'd0) begin
      mismatched++;
      $display("FAIL wrap_cnt: got %0d want 0", CNT);
    end
    compared++;
    if (pulses != 16) begin
      mismatched++;
      $display("FAIL wrap_pulses: got %0d want 16", pulses);
    end
  endtask

  initial begin
    CLR = 1'b0;
    EN  = 1'b0;
    D   = 1'b0;
    test_reset();
    test_stream();
    test_enable_hold();
    test_mid_reset();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
